// File: rtl/alu_issue_unit_if.sv
// Bundle of handshake, ALU, register-access and result signals of the issue unit.
// Latency: none (wires only).
// Backpressure: instr_ready gates instr_valid; the other groups have no flow control.
interface alu_issue_unit_if #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
);
    logic                  instr_valid;
    logic [4+3*RA_W-1:0]   instr;
    logic                  instr_ready;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [4:0]            alu_select;
    logic                  alu_c_in;
    logic [DATA_W-1:0]     alu_y;
    logic                  ext_we;
    logic [RA_W-1:0]       ext_addr;
    logic [DATA_W-1:0]     ext_data;
    logic [RA_W-1:0]       dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
    logic                  result_valid;
    logic [DATA_W-1:0]     result;
    logic [RA_W-1:0]       result_rd;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic                  z_flag;
`endif

    // Environment side: sends instructions, closes the ALU loop, pokes the register file.
    modport master (
`ifdef ALU_ISSUE_ZFLAG_EN
        input  z_flag,
`endif
        output instr_valid, instr, alu_y, ext_we, ext_addr, ext_data, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_select, alu_c_in, dbg_data,
               result_valid, result, result_rd
    );

    modport slave (
`ifdef ALU_ISSUE_ZFLAG_EN
        output z_flag,
`endif
        input  instr_valid, instr, alu_y, ext_we, ext_addr, ext_data, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_select, alu_c_in, dbg_data,
               result_valid, result, result_rd
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage wrapping a 4-bit ALU with a small register file (z_flag via ALU_ISSUE_ZFLAG_EN).
// Latency: accept at edge k, writeback at edge k+1, result_valid high after k+1; next accept at k+3.
// Backpressure: instr_ready is low outside IDLE and during reset; a held instr waits for IDLE.
module alu_issue_unit #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_unit_if.slave bus
);
    localparam int INSTR_W = 4 + 3*RA_W;
    localparam int NREG    = 2**RA_W;
    localparam logic [3:0] OP_NOP = 4'hF;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t              state;
    logic [RA_W-1:0]     rd_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   rf [NREG];

    logic [3:0]          op;
    logic [RA_W-1:0]     rd;
    logic [RA_W-1:0]     rs1;
    logic [RA_W-1:0]     rs2;

    assign op  = bus.instr[INSTR_W-1 -: 4];
    assign rd  = bus.instr[3*RA_W-1 -: RA_W];
    assign rs1 = bus.instr[2*RA_W-1 -: RA_W];
    assign rs2 = bus.instr[RA_W-1:0];

    assign bus.instr_ready = (state == IDLE) && rst_n;
    assign bus.dbg_data    = rf[bus.dbg_addr];

    // {select, c_in}; CLR and NOP share a code, NOP only differs by suppressing writeback.
    function automatic logic [5:0] decode(input logic [3:0] o);
        case (o)
            4'h0: decode = {5'b00000, 1'b0};
            4'h1: decode = {5'b00000, 1'b1};
            4'h2: decode = {5'b00001, 1'b0};
            4'h3: decode = {5'b00001, 1'b1};
            4'h4: decode = {5'b00010, 1'b0};
            4'h5: decode = {5'b00010, 1'b1};
            4'h6: decode = {5'b00011, 1'b0};
            4'h7: decode = {5'b00011, 1'b1};
            4'h8: decode = {5'b00100, 1'b0};
            4'h9: decode = {5'b00101, 1'b0};
            4'hA: decode = {5'b00110, 1'b0};
            4'hB: decode = {5'b00111, 1'b0};
            4'hC: decode = {5'b01000, 1'b0};
            4'hD: decode = {5'b10000, 1'b0};
            default: decode = {5'b11000, 1'b0};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            rd_q             <= '0;
            op_q             <= '0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_select   <= '0;
            bus.alu_c_in     <= 1'b0;
            bus.result       <= '0;
            bus.result_rd    <= '0;
            bus.result_valid <= 1'b0;
`ifdef ALU_ISSUE_ZFLAG_EN
            bus.z_flag       <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (bus.ext_we) rf[bus.ext_addr] <= bus.ext_data;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        bus.alu_a                     <= rf[rs1];
                        bus.alu_b                     <= rf[rs2];
                        {bus.alu_select, bus.alu_c_in} <= decode(op);
                        rd_q                          <= rd;
                        op_q                          <= op;
                        state                         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_q != OP_NOP) begin
                        // Placed after the ext write so a same-address collision resolves to the ALU result.
                        rf[rd_q]         <= bus.alu_y;
                        bus.result       <= bus.alu_y;
                        bus.result_rd    <= rd_q;
                        bus.result_valid <= 1'b1;
`ifdef ALU_ISSUE_ZFLAG_EN
                        bus.z_flag       <= (bus.alu_y == '0);
`endif
                        state            <= WB;
                    end else begin
                        state            <= IDLE;
                    end
                end
                WB: begin
                    bus.result_valid <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit; drives alu_y from a behavioural 4-bit ALU.
module tb_alu_issue_unit;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    alu_issue_unit_if #(.DATA_W(4), .RA_W(2)) bus ();

    alu_issue_unit #(.DATA_W(4), .RA_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [4:0] sel, input logic cin);
        logic [3:0] y;
        case (sel)
            5'b00000: y = cin ? a + 4'd1 : a;
            5'b00001: y = a + b + {3'b000, cin};
            5'b00010: y = a + ~b + {3'b000, cin};
            5'b00011: y = cin ? b : a - 4'd1;
            5'b00100: y = a & b;
            5'b00101: y = a | b;
            5'b00110: y = a ^ b;
            5'b00111: y = ~a;
            5'b01000: y = a << 1;
            5'b10000: y = a >> 1;
            default:  y = 4'h0;
        endcase
        return y;
    endfunction

    always_comb bus.alu_y = alu_model(bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input logic [1:0] addr, input logic [3:0] data);
        bus.ext_we   = 1'b1;
        bus.ext_addr = addr;
        bus.ext_data = data;
        tick();
        bus.ext_we   = 1'b0;
    endtask

    task automatic peek(input logic [1:0] addr, output logic [3:0] data);
        bus.dbg_addr = addr;
        #1;
        data = bus.dbg_data;
    endtask

    // Full instruction: accept, ISSUE, WB; captures the WB-cycle result outputs.
    task automatic do_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, output logic rv, output logic [3:0] r,
                         output logic [1:0] rr);
        bus.instr_valid = 1'b1;
        bus.instr       = {op, rd, rs1, rs2};
        tick();
        bus.instr_valid = 1'b0;
        tick();
        rv = bus.result_valid;
        r  = bus.result;
        rr = bus.result_rd;
        tick();
    endtask

    task automatic test_reset();
        logic [3:0] d;
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (bus.instr_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.instr_ready); else passed++;
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in} !== 14'h0)
            $display("FAIL reset_alu got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in}); else passed++;
        total++; if ({bus.result_valid, bus.result, bus.result_rd} !== 7'h0)
            $display("FAIL reset_result got %h want 0", {bus.result_valid, bus.result, bus.result_rd}); else passed++;
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d);
            total++; if (d !== 4'h0) $display("FAIL reset_rf%0d got %h want 0", i, d); else passed++;
        end
        // External write lands on the first edge after release.
        rst_n        = 1'b1;
        bus.ext_we   = 1'b1;
        bus.ext_addr = 2'd1;
        bus.ext_data = 4'h9;
        tick();
        bus.ext_we   = 1'b0;
        total++; if (bus.instr_ready !== 1'b1) $display("FAIL release_ready got %b want 1", bus.instr_ready); else passed++;
        peek(2'd1, d);
        total++; if (d !== 4'h9) $display("FAIL release_ext_we got %h want 9", d); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
        total++; if (bus.z_flag !== 1'b0) $display("FAIL reset_zflag got %b want 0", bus.z_flag); else passed++;
`endif
    endtask

    task automatic test_add();
        logic [3:0] d;
        ext_write(2'd1, 4'h5);
        ext_write(2'd2, 4'h3);
        bus.instr_valid = 1'b1;
        bus.instr       = {4'h2, 2'd0, 2'd1, 2'd2};
        tick();
        bus.instr_valid = 1'b0;
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in} !== {4'h5, 4'h3, 5'b00001, 1'b0})
            $display("FAIL add_issue got %h want %h", {bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in},
                     {4'h5, 4'h3, 5'b00001, 1'b0}); else passed++;
        total++; if ({bus.instr_ready, bus.result_valid} !== 2'b00)
            $display("FAIL add_issue_flags got %b want 00", {bus.instr_ready, bus.result_valid}); else passed++;
        tick();
        total++; if ({bus.result_valid, bus.result, bus.result_rd} !== {1'b1, 4'h8, 2'd0})
            $display("FAIL add_wb got %h want %h", {bus.result_valid, bus.result, bus.result_rd}, {1'b1, 4'h8, 2'd0}); else passed++;
        peek(2'd0, d);
        total++; if (d !== 4'h8) $display("FAIL add_rf0 got %h want 8", d); else passed++;
        tick();
        total++; if ({bus.instr_ready, bus.result_valid, bus.result, bus.alu_a} !== {1'b1, 1'b0, 4'h8, 4'h5})
            $display("FAIL add_idle_hold got %h want %h", {bus.instr_ready, bus.result_valid, bus.result, bus.alu_a},
                     {1'b1, 1'b0, 4'h8, 4'h5}); else passed++;
    endtask

    task automatic test_sub();
        logic rv; logic [3:0] r; logic [1:0] rr;
        ext_write(2'd0, 4'h5);
        ext_write(2'd1, 4'h3);
        do_op(4'h5, 2'd2, 2'd0, 2'd1, rv, r, rr);
        total++; if ({rv, r, rr} !== {1'b1, 4'h2, 2'd2}) $display("FAIL sub_fwd got %h want %h", {rv, r, rr}, {1'b1, 4'h2, 2'd2}); else passed++;
        do_op(4'h5, 2'd3, 2'd1, 2'd0, rv, r, rr);
        total++; if ({rv, r, rr} !== {1'b1, 4'hE, 2'd3}) $display("FAIL sub_wrap got %h want %h", {rv, r, rr}, {1'b1, 4'hE, 2'd3}); else passed++;
    endtask

    task automatic test_add_wrap_nop();
        logic rv; logic [3:0] r; logic [1:0] rr; logic [3:0] d;
        ext_write(2'd1, 4'hF);
        ext_write(2'd2, 4'h1);
        do_op(4'h2, 2'd1, 2'd1, 2'd2, rv, r, rr);
        total++; if ({rv, r, rr} !== {1'b1, 4'h0, 2'd1}) $display("FAIL add_wrap got %h want %h", {rv, r, rr}, {1'b1, 4'h0, 2'd1}); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
        total++; if (bus.z_flag !== 1'b1) $display("FAIL zflag_set got %b want 1", bus.z_flag); else passed++;
`endif
        ext_write(2'd3, 4'h6);
        do_op(4'hF, 2'd3, 2'd1, 2'd2, rv, r, rr);
        total++; if (rv !== 1'b0) $display("FAIL nop_pulse got %b want 0", rv); else passed++;
        peek(2'd3, d);
        total++; if (d !== 4'h6) $display("FAIL nop_nowrite got %h want 6", d); else passed++;
`ifdef ALU_ISSUE_ZFLAG_EN
        total++; if (bus.z_flag !== 1'b1) $display("FAIL zflag_nop got %b want 1", bus.z_flag); else passed++;
`endif
    endtask

    // All 16 ops with a=6, b=3 written to r3.
    task automatic test_decode();
        logic [5:0] sel_tab [16] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                                     6'b000110, 6'b000111, 6'b001000, 6'b001010, 6'b001100, 6'b001110,
                                     6'b010000, 6'b100000, 6'b110000, 6'b110000};
        logic [3:0] res_tab [16] = '{4'h6, 4'h7, 4'h9, 4'hA, 4'h2, 4'h3, 4'h5, 4'h3,
                                     4'h2, 4'h7, 4'h5, 4'h9, 4'hC, 4'h3, 4'h0, 4'h0};
        ext_write(2'd1, 4'h6);
        ext_write(2'd2, 4'h3);
        for (int op = 0; op < 16; op++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = {4'(op), 2'd3, 2'd1, 2'd2};
            tick();
            bus.instr_valid = 1'b0;
            total++; if ({bus.alu_select, bus.alu_c_in} !== sel_tab[op])
                $display("FAIL decode_op%0h got %b want %b", op, {bus.alu_select, bus.alu_c_in}, sel_tab[op]); else passed++;
            tick();
            if (op != 15) begin
                total++; if ({bus.result_valid, bus.result} !== {1'b1, res_tab[op]})
                    $display("FAIL result_op%0h got %h want %h", op, {bus.result_valid, bus.result}, {1'b1, res_tab[op]}); else passed++;
                tick();
            end else begin
                total++; if (bus.instr_ready !== 1'b1) $display("FAIL nop_to_idle got %b want 1", bus.instr_ready); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        ext_write(2'd0, 4'h7);
        bus.instr_valid = 1'b1;
        bus.instr       = {4'h1, 2'd0, 2'd0, 2'd0};
        tick();
        total++; if (bus.instr_ready !== 1'b0) $display("FAIL b2b_ready_issue got %b want 0", bus.instr_ready); else passed++;
        tick();
        total++; if ({bus.instr_ready, bus.result_valid, bus.result} !== {1'b0, 1'b1, 4'h8})
            $display("FAIL b2b_first got %h want %h", {bus.instr_ready, bus.result_valid, bus.result}, {1'b0, 1'b1, 4'h8}); else passed++;
        tick();
        total++; if ({bus.instr_ready, bus.result_valid} !== 2'b10)
            $display("FAIL b2b_idle got %b want 10", {bus.instr_ready, bus.result_valid}); else passed++;
        tick();
        bus.instr_valid = 1'b0;
        total++; if ({bus.instr_ready, bus.alu_a} !== {1'b0, 4'h8})
            $display("FAIL b2b_second_issue got %h want %h", {bus.instr_ready, bus.alu_a}, {1'b0, 4'h8}); else passed++;
        tick();
        total++; if ({bus.result_valid, bus.result} !== {1'b1, 4'h9})
            $display("FAIL b2b_second got %h want %h", {bus.result_valid, bus.result}, {1'b1, 4'h9}); else passed++;
        tick();
    endtask

    task automatic test_collision();
        logic [3:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            ext_write(2'd0, 4'h1);
            ext_write(2'd1, 4'h3);
            ext_write(2'd2, 4'h0);
            ext_write(2'd3, 4'h0);
            bus.instr_valid = 1'b1;
            bus.instr       = {4'h2, 2'd2, 2'd0, 2'd1};
            tick();
            bus.instr_valid = 1'b0;
            bus.ext_we      = 1'b1;
            bus.ext_addr    = (pass == 0) ? 2'd2 : 2'd3;
            bus.ext_data    = 4'hA;
            tick();
            bus.ext_we      = 1'b0;
            peek(2'd2, d);
            total++; if (d !== 4'h4) $display("FAIL collide%0d_r2 got %h want 4", pass, d); else passed++;
            if (pass == 1) begin
                peek(2'd3, d);
                total++; if (d !== 4'hA) $display("FAIL collide1_r3 got %h want a", d); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] d;
        ext_write(2'd1, 4'h5);
        ext_write(2'd2, 4'h3);
        bus.instr_valid = 1'b1;
        bus.instr       = {4'h2, 2'd0, 2'd1, 2'd2};
        tick();
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        total++; if ({bus.result_valid, bus.result, bus.result_rd, bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in} !== 21'h0)
            $display("FAIL midrst_outputs got %h want 0",
                     {bus.result_valid, bus.result, bus.result_rd, bus.alu_a, bus.alu_b, bus.alu_select, bus.alu_c_in}); else passed++;
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d);
            total++; if (d !== 4'h0) $display("FAIL midrst_rf%0d got %h want 0", i, d); else passed++;
        end
        rst_n = 1'b1;
        tick();
        total++; if ({bus.instr_ready, bus.result_valid} !== 2'b10)
            $display("FAIL midrst_release got %b want 10", {bus.instr_ready, bus.result_valid}); else passed++;
        tick();
        peek(2'd0, d);
        total++; if ({bus.result_valid, d} !== 5'h0) $display("FAIL midrst_no_wb got %h want 0", {bus.result_valid, d}); else passed++;
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ext_we      = 1'b0;
        bus.ext_addr    = '0;
        bus.ext_data    = '0;
        bus.dbg_addr    = '0;
        test_reset();
        test_add();
        test_sub();
        test_add_wrap_nop();
        test_decode();
        test_back_to_back();
        test_collision();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
